// File: rtl/icache_dm.sv
// Direct-mapped instruction cache between the fetch stage and instruction memory.
// A miss refills the whole line one word per acknowledged memory beat. A flush
// that arrives during a fill is deferred until the fill has completed.
module icache_dm #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16,
   parameter int LINES  = 4,
   parameter int WORDS  = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              req,
   input  logic              flush,
   input  logic [ADDR_W-1:0] address_in,
   output logic [DATA_W-1:0] inst_out,
   output logic              busy,
   output logic              mreq,
   output logic [ADDR_W-1:0] address_out,
   input  logic [DATA_W-1:0] from_mem,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int IDX_W = $clog2(LINES);
   localparam int OFF_W = $clog2(WORDS);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_DONE  = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [OFF_W-1:0]        ptr_q, ptr_d;
   logic [TAG_W-1:0]        fill_tag_q, fill_tag_d;
   logic [IDX_W-1:0]        fill_idx_q, fill_idx_d;
   logic                    flush_pend_q, flush_pend_d;
   logic [LINES-1:0]        valid_q, valid_d;
   logic [CNT_W-1:0]        miss_count_q, miss_count_d;
   logic [DATA_W-1:0]       inst_out_q, inst_out_d;

   logic [TAG_W-1:0]        tag_q  [LINES];
   logic [DATA_W-1:0]       data_q [LINES*WORDS];

   logic [TAG_W-1:0]        addr_tag;
   logic [IDX_W-1:0]        addr_idx;
   logic [OFF_W-1:0]        addr_off;
   logic                    miss;
   logic                    tag_we;
   logic                    data_we;
   logic [IDX_W+OFF_W-1:0]  data_waddr;

   assign addr_tag = address_in[ADDR_W-1 -: TAG_W];
   assign addr_idx = address_in[OFF_W +: IDX_W];
   assign addr_off = address_in[OFF_W-1:0];

   assign miss = req && !(valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag));

   assign busy        = clk_en && ((state_q != S_IDLE) || miss || flush);
   assign mreq        = clk_en && (state_q == S_FILL);
   assign address_out = {fill_tag_q, fill_idx_q, ptr_q};
   assign inst_out    = inst_out_q;
   assign miss_count  = miss_count_q;

   // Read port: present the addressed word on every enabled cycle, hit or not.
   always_comb begin
      inst_out_d = inst_out_q;
      if (clk_en) begin
         inst_out_d = data_q[{addr_idx, addr_off}];
      end else begin
         inst_out_d = inst_out_q;
      end
   end

   // Controller next state: miss capture, line refill, deferred and direct flush.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      fill_tag_d   = fill_tag_q;
      fill_idx_d   = fill_idx_q;
      flush_pend_d = flush_pend_q;
      valid_d      = valid_q;
      miss_count_d = miss_count_q;
      tag_we       = 1'b0;
      data_we      = 1'b0;
      data_waddr   = {fill_idx_q, ptr_q};
      if (clk_en) begin
         case (state_q)
            S_IDLE: begin
               if (flush) begin
                  state_d = S_FLUSH;
               end else if (miss) begin
                  fill_tag_d         = addr_tag;
                  fill_idx_d         = addr_idx;
                  valid_d[addr_idx]  = 1'b0;
                  tag_we             = 1'b1;
                  ptr_d              = {OFF_W{1'b0}};
                  if (miss_count_q != {CNT_W{1'b1}}) begin
                     miss_count_d = miss_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                  end else begin
                     miss_count_d = miss_count_q;
                  end
                  state_d = S_FILL;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_FILL: begin
               if (flush) begin
                  flush_pend_d = 1'b1;
               end else begin
                  flush_pend_d = flush_pend_q;
               end
               if (mem_ack) begin
                  data_we = 1'b1;
                  ptr_d   = ptr_q + {{(OFF_W-1){1'b0}}, 1'b1};
                  if (ptr_q == OFF_W'(WORDS-1)) begin
                     valid_d[fill_idx_q] = 1'b1;
                     state_d             = S_DONE;
                  end else begin
                     state_d = S_FILL;
                  end
               end else begin
                  state_d = S_FILL;
               end
            end
            S_DONE: begin
               // A flush arriving in this very cycle is honoured as well.
               if (flush_pend_q || flush) begin
                  state_d = S_FLUSH;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_FLUSH: begin
               valid_d      = {LINES{1'b0}};
               flush_pend_d = 1'b0;
               state_d      = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Control and status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= {OFF_W{1'b0}};
         fill_tag_q   <= {TAG_W{1'b0}};
         fill_idx_q   <= {IDX_W{1'b0}};
         flush_pend_q <= 1'b0;
         valid_q      <= {LINES{1'b0}};
         miss_count_q <= {CNT_W{1'b0}};
         inst_out_q   <= {DATA_W{1'b0}};
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         fill_tag_q   <= fill_tag_d;
         fill_idx_q   <= fill_idx_d;
         flush_pend_q <= flush_pend_d;
         valid_q      <= valid_d;
         miss_count_q <= miss_count_d;
         inst_out_q   <= inst_out_d;
      end
   end

   // Tag and data storage; contents are qualified by the valid bits, so no reset.
   always_ff @(posedge clk) begin
      if (!rst && tag_we) begin
         tag_q[addr_idx] <= addr_tag;
      end
      if (!rst && data_we) begin
         data_q[data_waddr] <= from_mem;
      end
   end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: memory answers addr ^ 16'hA5A5.
module tb_icache_dm;

   logic        clk;
   logic        rst;
   logic        clk_en;
   logic        req;
   logic        flush;
   logic [9:0]  address_in;
   logic [15:0] inst_out;
   logic        busy;
   logic        mreq;
   logic [9:0]  address_out;
   logic [15:0] from_mem;
   logic        mem_ack;
   logic [15:0] miss_count;

   logic [15:0] inst_out2;
   logic        busy2;
   logic        mreq2;
   logic [9:0]  address_out2;
   logic [1:0]  miss_count2;

   int n_checks = 0;
   int n_fail   = 0;

   icache_dm dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .req(req), .flush(flush),
      .address_in(address_in), .inst_out(inst_out), .busy(busy), .mreq(mreq),
      .address_out(address_out), .from_mem(from_mem), .mem_ack(mem_ack),
      .miss_count(miss_count)
   );

   // Same traffic into a narrow-counter instance to see saturation.
   icache_dm #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .clk_en(clk_en), .req(req), .flush(flush),
      .address_in(address_in), .inst_out(inst_out2), .busy(busy2), .mreq(mreq2),
      .address_out(address_out2), .from_mem(from_mem), .mem_ack(mem_ack),
      .miss_count(miss_count2)
   );

   function automatic logic [15:0] exp_word(input logic [9:0] a);
      return {6'b000000, a} ^ 16'hA5A5;
   endfunction

   assign from_mem = exp_word(address_out);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One fetch of addr that is expected to miss; counts busy and fill cycles,
   // checks every memory address, optionally pulses flush or disturbs address_in.
   task automatic access(input logic [9:0] addr, input bit toggle, input int flush_at,
                         input int chg_at, input int exp_busy, input int exp_fill);
      int nbusy;
      int nfill;
      logic [9:0] exp_addr;
      nbusy = 0;
      nfill = 0;
      exp_addr = {addr[9:3], 3'b000};
      address_in = addr;
      req = 1'b1;
      mem_ack = 1'b1;
      #1;
      while (busy === 1'b1 && nbusy < 100) begin
         if (mreq === 1'b1) begin
            chk("fill_addr", address_out, exp_addr);
            if (mem_ack) exp_addr = exp_addr + 10'd1;
            nfill++;
         end
         nbusy++;
         tick();
         req = 1'b0;
         flush = 1'b0;
         if (toggle) mem_ack = ~mem_ack;
         if (nfill == flush_at) flush = 1'b1;
         if (nfill == chg_at) address_in = 10'h3FF;
         if (nfill == chg_at + 4) address_in = addr;
         #1;
      end
      chk("busy_cycles", nbusy, exp_busy);
      chk("fill_cycles", nfill, exp_fill);
      tick();
      chk("fill_data", inst_out, exp_word(addr));
   endtask

   task automatic hit(input logic [9:0] addr);
      address_in = addr;
      req = 1'b1;
      #1;
      chk("hit_busy", busy, 1'b0);
      tick();
      req = 1'b0;
      #1;
      chk("hit_data", inst_out, exp_word(addr));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      int n;
      rst = 1'b1; clk_en = 1'b1; req = 1'b0; flush = 1'b0;
      address_in = 10'h000; mem_ack = 1'b0;
      do_reset();
      chk("rst_inst_out", inst_out, 16'h0000);
      chk("rst_miss_count", miss_count, 16'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_mreq", mreq, 1'b0);

      // Cold miss with mem_ack high: 10 busy cycles, 8 beats 0x120..0x127.
      access(10'h123, 1'b0, -1, -1, 10, 8);
      chk("t1_miss_count", miss_count, 16'd1);

      // Hits on the filled line.
      hit(10'h121);
      hit(10'h127);
      chk("t2_miss_count", miss_count, 16'd1);

      // Back-pressure on line idx 1, address_in disturbed mid-fill.
      access(10'h04D, 1'b1, -1, 4, 18, 16);
      chk("t3_miss_count", miss_count, 16'd2);
      hit(10'h04F);

      // Conflict misses on idx 0 from a clean cache.
      do_reset();
      access(10'h120, 1'b0, -1, -1, 10, 8);
      access(10'h220, 1'b0, -1, -1, 10, 8);
      chk("t4_sat_count_2", miss_count2, 2'd2);
      access(10'h120, 1'b0, -1, -1, 10, 8);
      chk("t4_miss_count", miss_count, 16'd3);
      chk("t4_sat_count_3", miss_count2, 2'd3);

      // Flush during fill: DONE then FLUSH adds one busy cycle, line then misses.
      access(10'h1D3, 1'b0, 3, -1, 11, 8);
      access(10'h1D3, 1'b0, -1, -1, 10, 8);
      // Flush from IDLE: busy in the pulse cycle and the FLUSH cycle only.
      req = 1'b0;
      flush = 1'b1;
      #1;
      chk("idle_flush_busy0", busy, 1'b1);
      tick();
      flush = 1'b0;
      #1;
      chk("idle_flush_busy1", busy, 1'b1);
      tick();
      chk("idle_flush_busy2", busy, 1'b0);
      access(10'h1D3, 1'b0, -1, -1, 10, 8);
      chk("t5_miss_count", miss_count, 16'd6);
      chk("t5_sat_count", miss_count2, 2'd3);

      // Reset in the middle of a fill.
      address_in = 10'h2A8; req = 1'b1; mem_ack = 1'b1;
      tick();
      req = 1'b0;
      tick();
      tick();
      chk("mid_fill_mreq", mreq, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_mreq", mreq, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_count", miss_count, 16'd0);
      access(10'h2A8, 1'b0, -1, -1, 10, 8);

      // clk_en low for five cycles with ptr at 3.
      address_in = 10'h3FA; req = 1'b1; mem_ack = 1'b1;
      #1;
      chk("ce_miss_busy", busy, 1'b1);
      tick();
      req = 1'b0;
      tick();
      tick();
      tick();
      chk("ce_pre_mreq", mreq, 1'b1);
      chk("ce_pre_addr", address_out, 10'h3FB);
      clk_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("ce_low_busy", busy, 1'b0);
         chk("ce_low_mreq", mreq, 1'b0);
         chk("ce_low_addr", address_out, 10'h3FB);
         tick();
      end
      clk_en = 1'b1;
      #1;
      chk("ce_resume_mreq", mreq, 1'b1);
      chk("ce_resume_addr", address_out, 10'h3FB);
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         n++;
         tick();
      end
      chk("ce_rest_busy", n, 6);
      tick();
      chk("ce_fill_data", inst_out, exp_word(10'h3FA));
      hit(10'h3FD);

      // Enable low: a missing request and a flush are both ignored, outputs hold.
      clk_en = 1'b0; address_in = 10'h127; req = 1'b1; flush = 1'b1;
      #1;
      chk("ce_off_busy", busy, 1'b0);
      tick();
      tick();
      chk("ce_off_inst_hold", inst_out, exp_word(10'h3FD));
      chk("ce_off_count_hold", miss_count, 16'd2);
      clk_en = 1'b1; req = 1'b0; flush = 1'b0;
      hit(10'h3FD);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
